// File: rtl/tensor_core_operand_buffer.sv
// ---------------------------------------------------------------------------
// tensor_core_operand_buffer
//
// Register file holding NUM_MATRICES square DIM x DIM signed operand
// matrices for a tensor core. The storage is addressed by a flat index
// k = m*DIM*DIM + r*DIM + c. It has three write paths. In priority order
// they are:
//   1. bulk write   - every register loaded in a single cycle
//   2. burst load   - LANES elements per accepted beat, under a small
//                     IDLE/LOAD FSM; the address wraps modulo TOTAL
//   3. single write - one element at a flat address
// A write that loses the priority contest is dropped.
// All read paths are combinational views of the registers.
//
// Ports
//   clock_in, reset_in               clock and async active-high reset
//   single_write_*_in                single-element write strobe/addr/data
//   single_read_address_in/_data_out combinational single-element read
//   load_start_in, load_start_address_in, load_count_in
//                                    burst set-up (ignored while busy)
//   load_valid_in, load_data_in      beat handshake and data (lane 0 first)
//   load_ready_out, load_busy_out    beat acceptance / FSM in LOAD
//   load_done_out                    one-cycle pulse after a burst ends
//   bulk_write_enable_in, bulk_write_data_in, bulk_read_data_out
//                                    whole-array write and view
//
// Optional feature: define TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN to add
// load_transpose_in. This input is latched at burst start. It makes the
// burst store each matrix transposed. Single and bulk writes are not
// affected.
// ---------------------------------------------------------------------------
module tensor_core_operand_buffer #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int DIM          = 3,
  parameter  int NUM_MATRICES = 2,
  parameter  int LANES        = 4,
  localparam int DD           = DIM * DIM,
  localparam int TOTAL        = NUM_MATRICES * DD,
  localparam int AW           = $clog2(TOTAL),
  localparam int CW           = $clog2(TOTAL + 1)
) (
  input  logic                                                        clock_in,
  input  logic                                                        reset_in,
  input  logic                                                        single_write_enable_in,
  input  logic [AW-1:0]                                               single_write_address_in,
  input  logic signed [DATA_WIDTH-1:0]                                single_write_data_in,
  input  logic [AW-1:0]                                               single_read_address_in,
  output logic signed [DATA_WIDTH-1:0]                                single_read_data_out,
  input  logic                                                        load_start_in,
  input  logic [AW-1:0]                                               load_start_address_in,
  input  logic [CW-1:0]                                               load_count_in,
`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
  input  logic                                                        load_transpose_in,
`endif
  input  logic                                                        load_valid_in,
  input  logic signed [LANES-1:0][DATA_WIDTH-1:0]                     load_data_in,
  output logic                                                        load_ready_out,
  output logic                                                        load_busy_out,
  output logic                                                        load_done_out,
  input  logic                                                        bulk_write_enable_in,
  input  logic signed [NUM_MATRICES-1:0][DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] bulk_write_data_in,
  output logic signed [NUM_MATRICES-1:0][DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] bulk_read_data_out
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] regs      [TOTAL];
  logic [DATA_WIDTH-1:0] bulk_flat [TOTAL];
  logic [DATA_WIDTH-1:0] lane_data [LANES];

  logic [AW-1:0] pointer_q, pointer_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          done_q, done_d;
  logic          start_accept;
  logic          beat_fire;
  logic          transpose_active;
  int            take;

  logic [LANES-1:0] lane_we;
  logic [AW-1:0]    lane_idx [LANES];

`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
  logic transpose_q;

  // The transpose choice is held for the whole burst. It is captured only
  // when a start is actually taken.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      transpose_q <= 1'b0;
    end else if (start_accept) begin
      transpose_q <= load_transpose_in;
    end
  end

  assign transpose_active = transpose_q;
`else
  assign transpose_active = 1'b0;
`endif

  // Map a logical burst index to its physical register index. With
  // transpose active, row and column are swapped within each matrix.
  function automatic int map_index(input int k, input logic tr);
    int m;
    int p;
    m = k / DD;
    p = k % DD;
    if (tr) begin
      return m * DD + (p % DIM) * DIM + p / DIM;
    end
    return k;
  endfunction

  // Map the multi-dimensional bulk ports to and from the flat register array.
  for (genvar gm = 0; gm < NUM_MATRICES; gm++) begin : g_mat
    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < DIM; gc++) begin : g_col
        assign bulk_flat[gm*DD + gr*DIM + gc]        = bulk_write_data_in[gm][gr][gc];
        assign bulk_read_data_out[gm][gr][gc]        = regs[gm*DD + gr*DIM + gc];
      end
    end
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    assign lane_data[gl] = load_data_in[gl];
  end

  // An out-of-range read address returns zero. It does not alias onto a
  // real register.
  assign single_read_data_out = (int'(single_read_address_in) < TOTAL) ?
                                regs[single_read_address_in] : '0;

  assign start_accept = (state_q == IDLE) && load_start_in && (load_count_in != '0);
  assign beat_fire    = load_valid_in && load_ready_out;

  // Beat address generation. Each lane lands at pointer+i modulo TOTAL.
  // Only lanes below the remaining count are enabled. This discards the
  // excess lanes of a short final beat.
  always_comb begin
    take        = (int'(remaining_q) < LANES) ? int'(remaining_q) : LANES;
    remaining_d = remaining_q - CW'(take);
    pointer_d   = AW'((int'(pointer_q) + LANES) % TOTAL);
    lane_we     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i] = AW'(map_index((int'(pointer_q) + i) % TOTAL, transpose_active));
      lane_we[i]  = (i < int'(remaining_q));
    end
  end

  // FSM next-state and handshake outputs. The bulk write takes the array
  // for the cycle, so ready is withheld while it is active. Done is
  // registered, which makes it appear the cycle after the burst ends or
  // after an empty start.
  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    load_busy_out  = (state_q == LOAD);
    load_ready_out = (state_q == LOAD) && !bulk_write_enable_in;
    case (state_q)
      IDLE: begin
        if (load_start_in) begin
          if (load_count_in != '0) begin
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat_fire && (remaining_d == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_done_out = done_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Burst bookkeeping. A new start overwrites pointer and remaining. Each
  // accepted beat advances them by one beat's worth.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pointer_q   <= '0;
      remaining_q <= '0;
    end else if (start_accept) begin
      pointer_q   <= load_start_address_in;
      remaining_q <= load_count_in;
    end else if (beat_fire) begin
      pointer_q   <= pointer_d;
      remaining_q <= remaining_d;
    end
  end

  // Register array. At most one write source acts per cycle, chosen in
  // priority order: bulk, then beat, then single.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < TOTAL; k++) begin
        regs[k] <= '0;
      end
    end else if (bulk_write_enable_in) begin
      for (int k = 0; k < TOTAL; k++) begin
        regs[k] <= bulk_flat[k];
      end
    end else if (beat_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) begin
          regs[lane_idx[i]] <= lane_data[i];
        end
      end
    end else if (single_write_enable_in && (int'(single_write_address_in) < TOTAL)) begin
      regs[single_write_address_in] <= single_write_data_in;
    end
  end

endmodule

// File: tb/tb_tensor_core_operand_buffer.sv
// ---------------------------------------------------------------------------
// tb_tensor_core_operand_buffer
//
// Directed bench for tensor_core_operand_buffer with default parameters
// (8-bit data, 3x3 matrices, 2 matrices, 4 lanes, so 18 registers).
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// after that same offset, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_tensor_core_operand_buffer;

  logic                          clock_in;
  logic                          reset_in;
  logic                          single_write_enable_in;
  logic [4:0]                    single_write_address_in;
  logic signed [7:0]             single_write_data_in;
  logic [4:0]                    single_read_address_in;
  logic signed [7:0]             single_read_data_out;
  logic                          load_start_in;
  logic [4:0]                    load_start_address_in;
  logic [4:0]                    load_count_in;
`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
  logic                          load_transpose_in;
`endif
  logic                          load_valid_in;
  logic signed [3:0][7:0]        load_data_in;
  logic                          load_ready_out;
  logic                          load_busy_out;
  logic                          load_done_out;
  logic                          bulk_write_enable_in;
  logic signed [1:0][2:0][2:0][7:0] bulk_write_data_in;
  logic signed [1:0][2:0][2:0][7:0] bulk_read_data_out;

  int checks = 0;
  int errors = 0;

  tensor_core_operand_buffer dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .single_write_enable_in  (single_write_enable_in),
    .single_write_address_in (single_write_address_in),
    .single_write_data_in    (single_write_data_in),
    .single_read_address_in  (single_read_address_in),
    .single_read_data_out    (single_read_data_out),
    .load_start_in           (load_start_in),
    .load_start_address_in   (load_start_address_in),
    .load_count_in           (load_count_in),
`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
    .load_transpose_in       (load_transpose_in),
`endif
    .load_valid_in           (load_valid_in),
    .load_data_in            (load_data_in),
    .load_ready_out          (load_ready_out),
    .load_busy_out           (load_busy_out),
    .load_done_out           (load_done_out),
    .bulk_write_enable_in    (bulk_write_enable_in),
    .bulk_write_data_in      (bulk_write_data_in),
    .bulk_read_data_out      (bulk_read_data_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Present one load beat (lane 0 is the lowest index).
  task automatic applyStimulus(input logic valid, input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
    load_valid_in = valid;
    load_data_in  = {l3, l2, l1, l0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  function automatic logic [7:0] regAt(input int k);
    return bulk_read_data_out[1'(k / 9)][2'((k % 9) / 3)][2'(k % 3)];
  endfunction

  task automatic startLoad(input logic [4:0] addr, input logic [4:0] count);
    load_start_in         = 1'b1;
    load_start_address_in = addr;
    load_count_in         = count;
  endtask

  initial begin
    reset_in                = 1'b1;
    single_write_enable_in  = 1'b0;
    single_write_address_in = '0;
    single_write_data_in    = '0;
    single_read_address_in  = '0;
    load_start_in           = 1'b0;
    load_start_address_in   = '0;
    load_count_in           = '0;
`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
    load_transpose_in       = 1'b0;
`endif
    load_valid_in           = 1'b0;
    load_data_in            = '0;
    bulk_write_enable_in    = 1'b0;
    bulk_write_data_in      = '0;

    // Reset state
    #1;
    checkOutput("reset_busy", 32'(load_busy_out), 0);
    checkOutput("reset_ready", 32'(load_ready_out), 0);
    checkOutput("reset_done", 32'(load_done_out), 0);
    checkOutput("reset_read", 32'(single_read_data_out), 0);
    tick();
    reset_in = 1'b0;
    tick();

    // Full 18-element burst, five continuous beats carrying 1..20
    startLoad(5'd0, 5'd18);
    tick();
    load_start_in = 1'b0;
    checkOutput("full_busy", 32'(load_busy_out), 1);
    checkOutput("full_ready", 32'(load_ready_out), 1);
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, 8'(4*b+1), 8'(4*b+2), 8'(4*b+3), 8'(4*b+4));
      tick();
      if (b < 4) begin
        checkOutput($sformatf("full_no_done_b%0d", b), 32'(load_done_out), 0);
        checkOutput($sformatf("full_busy_b%0d", b), 32'(load_busy_out), 1);
      end
    end
    checkOutput("full_done", 32'(load_done_out), 1);
    checkOutput("full_idle", 32'(load_busy_out), 0);
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkOutput("full_done_drop", 32'(load_done_out), 0);
    for (int k = 0; k < 18; k++) begin
      checkOutput($sformatf("full_reg%0d", k), 32'(regAt(k)), 32'(k + 1));
    end

    // Wrapping burst starting at 16
    startLoad(5'd16, 5'd4);
    tick();
    load_start_in = 1'b0;
    applyStimulus(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("wrap_done", 32'(load_done_out), 1);
    checkOutput("wrap_reg16", 32'(regAt(16)), 5);
    checkOutput("wrap_reg17", 32'(regAt(17)), 6);
    checkOutput("wrap_reg0", 32'(regAt(0)), 7);
    checkOutput("wrap_reg1", 32'(regAt(1)), 8);
    checkOutput("wrap_reg2", 32'(regAt(2)), 3);
    tick();

    // A start asserted while in LOAD must not re-aim the burst
    startLoad(5'd8, 5'd4);
    tick();
    startLoad(5'd0, 5'd1);
    applyStimulus(1'b1, 8'd21, 8'd22, 8'd23, 8'd24);
    tick();
    load_start_in = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("ign_done", 32'(load_done_out), 1);
    checkOutput("ign_reg8", 32'(regAt(8)), 21);
    checkOutput("ign_reg11", 32'(regAt(11)), 24);
    checkOutput("ign_reg0", 32'(regAt(0)), 7);
    tick();
    checkOutput("ign_idle", 32'(load_busy_out), 0);

    // Zero-count start: no LOAD, done pulses next cycle only
    startLoad(5'd3, 5'd0);
    tick();
    load_start_in = 1'b0;
    checkOutput("zero_done", 32'(load_done_out), 1);
    checkOutput("zero_busy", 32'(load_busy_out), 0);
    tick();
    checkOutput("zero_done_drop", 32'(load_done_out), 0);

    // Bulk write during LOAD stalls the beat and beats a single write
    startLoad(5'd0, 5'd4);
    tick();
    load_start_in = 1'b0;
    applyStimulus(1'b1, 8'd50, 8'd51, 8'd52, 8'd53);
    bulk_write_enable_in = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          bulk_write_data_in[1'(m)][2'(r)][2'(c)] = 8'(m*9 + r*3 + c + 100);
    single_write_enable_in  = 1'b1;
    single_write_address_in = 5'd5;
    single_write_data_in    = 8'sd77;
    #1;
    checkOutput("bulk_ready_low", 32'(load_ready_out), 0);
    tick();
    single_write_enable_in = 1'b0;
    checkOutput("bulk_ready_hold", 32'(load_ready_out), 0);
    checkOutput("bulk_reg0", 32'(regAt(0)), 100);
    checkOutput("bulk_reg5", 32'(regAt(5)), 105);
    tick();
    checkOutput("bulk_still_busy", 32'(load_busy_out), 1);
    checkOutput("bulk_no_done", 32'(load_done_out), 0);
    bulk_write_enable_in    = 1'b0;
    single_write_enable_in  = 1'b1;
    single_write_address_in = 5'd0;
    single_write_data_in    = 8'sd99;
    #1;
    checkOutput("bulk_ready_back", 32'(load_ready_out), 1);
    tick();
    single_write_enable_in = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("bulk_beat_done", 32'(load_done_out), 1);
    checkOutput("bulk_beat_reg0", 32'(regAt(0)), 50);
    checkOutput("bulk_beat_reg3", 32'(regAt(3)), 53);
    checkOutput("bulk_beat_reg4", 32'(regAt(4)), 104);
    checkOutput("bulk_reg17", 32'(regAt(17)), 117);

    // Single write / read, including out-of-range addresses
    single_write_enable_in  = 1'b1;
    single_write_address_in = 5'd4;
    single_write_data_in    = -8'sd3;
    single_read_address_in  = 5'd4;
    tick();
    checkOutput("single_rd4", 32'(single_read_data_out), -32'sd3);
    single_write_address_in = 5'd20;
    single_write_data_in    = 8'sd9;
    tick();
    single_write_enable_in = 1'b0;
    checkOutput("single_oor_reg2", 32'(regAt(2)), 52);
    checkOutput("single_oor_reg4", 32'(single_read_data_out), -32'sd3);
    checkOutput("single_oor_reg17", 32'(regAt(17)), 117);
    single_read_address_in = 5'd20;
    #1;
    checkOutput("single_rd20", 32'(single_read_data_out), 0);

    // Asynchronous reset after two beats of an 18-element burst
    tick();
    startLoad(5'd0, 5'd18);
    tick();
    load_start_in = 1'b0;
    applyStimulus(1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    applyStimulus(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    #2;
    reset_in = 1'b1;
    single_read_address_in = 5'd0;
    #1;
    checkOutput("arst_busy", 32'(load_busy_out), 0);
    checkOutput("arst_ready", 32'(load_ready_out), 0);
    checkOutput("arst_done", 32'(load_done_out), 0);
    checkOutput("arst_read0", 32'(single_read_data_out), 0);
    checkOutput("arst_reg5", 32'(regAt(5)), 0);
    reset_in = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("arst_no_done_%0d", i), 32'(load_done_out), 0);
    end
    startLoad(5'd0, 5'd4);
    tick();
    load_start_in = 1'b0;
    applyStimulus(1'b1, 8'd9, 8'd10, 8'd11, 8'd12);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("arst_reload_done", 32'(load_done_out), 1);
    checkOutput("arst_reload_reg0", 32'(regAt(0)), 9);
    checkOutput("arst_reload_reg3", 32'(regAt(3)), 12);
    checkOutput("arst_reload_reg4", 32'(regAt(4)), 0);
    tick();

`ifdef TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN
    // Transposed load of matrix 0 with 1..9
    load_transpose_in = 1'b1;
    startLoad(5'd0, 5'd9);
    tick();
    load_start_in     = 1'b0;
    load_transpose_in = 1'b0;
    applyStimulus(1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    applyStimulus(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    applyStimulus(1'b1, 8'd9, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("tr_done", 32'(load_done_out), 1);
    checkOutput("tr_001", 32'(bulk_read_data_out[0][1][0] === 8'd2), 1);
    checkOutput("tr_010", 32'(bulk_read_data_out[0][0][1]), 4);
    checkOutput("tr_022", 32'(bulk_read_data_out[0][2][2]), 9);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_core_operand_buffer.md
TENSOR_CORE_OPERAND_BUFFER -- requirements
Module: tensor_core_operand_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, signed element width in bits.
REQ-002 Parameter DIM, default 3, matrix rows = columns.
REQ-003 Parameter NUM_MATRICES, default 2, number of operand matrices held.
REQ-004 Parameter LANES, default 4, elements accepted per load beat.
REQ-005 Derived: TOTAL = NUM_MATRICES*DIM*DIM; AW = $clog2(TOTAL); CW = $clog2(TOTAL+1); flat index k = m*DIM*DIM + r*DIM + c.
REQ-006 clock_in  input  1  sole clock, rising edge.
REQ-007 reset_in  input  1  reset, asynchronous, active-high.
REQ-008 single_write_enable_in  input  1  single-element write strobe.
REQ-009 single_write_address_in  input  AW  flat write index.
REQ-010 single_write_data_in  input  DATA_WIDTH signed  write data.
REQ-011 single_read_address_in  input  AW  flat read index.
REQ-012 single_read_data_out  output  DATA_WIDTH signed  combinational read data.
REQ-013 load_start_in  input  1  start burst load.
REQ-014 load_start_address_in  input  AW  first flat index of burst.
REQ-015 load_count_in  input  CW  burst length in elements.
REQ-016 load_valid_in  input  1  beat valid.
REQ-017 load_data_in  input  [LANES] x DATA_WIDTH signed  beat data, lane 0 lowest index.
REQ-018 load_ready_out  output  1  beat accepted when valid and ready both high.
REQ-019 load_busy_out  output  1  FSM in LOAD.
REQ-020 load_done_out  output  1  one-cycle pulse at burst completion.
REQ-021 bulk_write_enable_in  input  1  whole-array write strobe.
REQ-022 bulk_write_data_in  input  [NUM_MATRICES][DIM][DIM] x DATA_WIDTH signed  whole-array data.
REQ-023 bulk_read_data_out  output  [NUM_MATRICES][DIM][DIM] x DATA_WIDTH signed  combinational view of all registers.

Function
REQ-024 FSM states IDLE, LOAD; load_busy_out = (state==LOAD); load_ready_out = (state==LOAD) && !bulk_write_enable_in.
REQ-025 IDLE + load_start_in, count>0: latch pointer=start address, remaining=count; go LOAD next cycle.
REQ-026 IDLE + load_start_in, count==0: stay IDLE; load_done_out pulses next cycle.
REQ-027 load_start_in while in LOAD is ignored.
REQ-028 Accepted beat writes lanes 0..min(LANES,remaining)-1 to index (pointer+i) mod TOTAL; remaining lanes discarded.
REQ-029 Per beat: pointer = (pointer+LANES) mod TOTAL; remaining -= min(LANES,remaining).
REQ-030 Beat bringing remaining to 0: state IDLE next cycle, load_done_out high exactly that next cycle.
REQ-031 Write priority per cycle: bulk write > accepted beat > single write; losing writes dropped entirely.
REQ-032 Single write with address >= TOTAL ignored; single read with address >= TOTAL returns 0.
REQ-033 All writes registered: visible on read outputs cycle after the write edge.

Reset
REQ-034 reset_in high: all registers 0, state IDLE, pointer/remaining 0, load_ready_out/load_busy_out/load_done_out 0, immediately without clock edge.
REQ-035 Reset mid-burst abandons burst; no done pulse issued.

Configuration
REQ-036 Macro TENSOR_CORE_OPERAND_BUFFER_TRANSPOSE_EN.
REQ-037 Defined: extra input load_transpose_in (1 bit), latched on accepted load_start_in; when latched 1, logical index k maps to physical m*DIM*DIM + (p%DIM)*DIM + p/DIM with m=k/(DIM*DIM), p=k%(DIM*DIM); single and bulk writes unaffected.
REQ-038 Undefined: port absent; loads use identity mapping.

Verification
REQ-039 Default params; load start 0 count 18, 5 continuous beats data 1..20 -> registers k hold k+1 for k=0..17, lanes 2,3 of beat 5 dropped, done pulse one cycle after beat 5.
REQ-040 Load start 16 count 4, one beat {5,6,7,8} -> reg16=5, reg17=6, reg0=7, reg1=8 (wrap).
REQ-041 During LOAD hold bulk_write_enable_in high with valid high -> ready 0, bulk data written, beat consumed on first cycle after bulk drops.
REQ-042 Single write addr 4 data -3 -> read addr 4 = -3 next cycle; single write addr 20 -> no change; read addr 20 -> 0.
REQ-043 Assert reset_in asynchronously after beat 2 of an 18-element load -> all outputs 0 immediately, no done pulse, next start loads normally.
REQ-044 Macro defined, transpose 1, start 0 count 9, data 1..9 -> bulk_read_data_out[0][0][1]=4, [0][1][0]=2, [0][2][2]=9.
